// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the memory port arbiter (FSM state, owner, grant vector).
package mem_arb_pkg;
  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MX} arb_owner_e;
  typedef struct packed {
    logic if_g;
    logic mx_g;
  } arb_gnt_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: one-hot grant pick, MX over IF unless IF is starved.
// Ports: slot (issue slot open), if_req, mx_req, starved (starve limit hit), gnt (one-hot grant).
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic     slot,
  input  logic     if_req,
  input  logic     mx_req,
  input  logic     starved,
  output arb_gnt_t gnt
);
  logic if_wins;
  assign if_wins  = if_req && (starved || !mx_req);
  assign gnt.if_g = slot && if_wins;
  assign gnt.mx_g = slot && mx_req && !if_wins;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between IF (reads) and MX (loads/stores).
// Ports: clk/rst; IF req/addr -> gnt/rvalid/rdata/err; MX req/wr/addr/wdata -> gnt/rvalid/rdata/err;
//        mem_addr/enable/wr/data_in to the RAM, mem_data_out/err back from it.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              mx_req,
  input  logic              mx_wr,
  input  logic [ADDR_W-1:0] mx_addr,
  input  logic [DATA_W-1:0] mx_wdata,
  output logic              mx_gnt,
  output logic              mx_rvalid,
  output logic [DATA_W-1:0] mx_rdata,
  output logic              mx_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_err
);
  localparam int LW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q, owner_d;
  logic [LW-1:0]     lat_q, lat_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy, done, slot, starved, any_gnt;
  arb_gnt_t          gnt;
  // rst gates everything combinational so nothing leaks out while an access is abandoned
  assign busy    = !rst && state_q == ARB_BUSY;
  assign done    = busy && lat_q == '0;
  assign slot    = !rst && (state_q == ARB_IDLE || lat_q == '0);
  assign starved = starve_q == SW'(STARVE_MAX);
  mem_arb_pick u_pick (
    .slot   (slot),
    .if_req (if_req),
    .mx_req (mx_req),
    .starved(starved),
    .gnt    (gnt)
  );
  assign if_gnt      = gnt.if_g;
  assign mx_gnt      = gnt.mx_g;
  assign any_gnt     = gnt.if_g || gnt.mx_g;
  assign if_rvalid   = done && owner_q == OWN_IF;
  assign mx_rvalid   = done && owner_q == OWN_MX;
  assign if_rdata    = if_rvalid ? mem_data_out : '0;
  assign mx_rdata    = mx_rvalid && !wr_q ? mem_data_out : '0;
  assign if_err      = if_rvalid && mem_err;
  assign mx_err      = mx_rvalid && mem_err;
  assign mem_enable  = busy;
  assign mem_addr    = addr_q;
  assign mem_wr      = wr_q;
  assign mem_data_in = wdata_q;
  always_comb begin
    state_d  = slot ? (any_gnt ? ARB_BUSY : ARB_IDLE) : state_q;
    owner_d  = gnt.mx_g ? OWN_MX : gnt.if_g ? OWN_IF : slot ? OWN_NONE : owner_q;
    lat_d    = any_gnt ? LW'(MEM_LAT - 1) : lat_q != '0 ? lat_q - LW'(1) : lat_q;
    addr_d   = gnt.mx_g ? mx_addr : gnt.if_g ? if_addr : addr_q;
    wr_d     = gnt.mx_g ? mx_wr : gnt.if_g ? 1'b0 : wr_q;
    wdata_d  = gnt.mx_g ? mx_wdata : wdata_q;
    // counts MX wins that IF had to sit through; any IF win or IF giving up clears it
    starve_d = !if_req || gnt.if_g ? '0 : gnt.mx_g && !starved ? starve_q + SW'(1) : starve_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= OWN_NONE;
      lat_q    <= '0;
      starve_q <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      lat_q    <= lat_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of the arbiter at MEM_LAT=1 (u1) and MEM_LAT=3 (u3).
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst = 1'b1;
  logic if_req = 0, mx_req = 0, mx_wr = 0, mem_err = 0;
  logic [15:0] if_addr = 0, mx_addr = 0, mx_wdata = 0;
  logic if_gnt_1, if_rvalid_1, if_err_1, mx_gnt_1, mx_rvalid_1, mx_err_1, en_1, wr_1;
  logic [15:0] if_rdata_1, mx_rdata_1, addr_1, din_1, dout_1;
  logic if_gnt_3, if_rvalid_3, if_err_3, mx_gnt_3, mx_rvalid_3, mx_err_3, en_3, wr_3;
  logic [15:0] if_rdata_3, mx_rdata_3, addr_3, din_3, dout_3;
  logic [15:0] mem1 [0:255];
  logic [15:0] mem3 [0:255];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u1 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_1),
    .if_rvalid(if_rvalid_1), .if_rdata(if_rdata_1), .if_err(if_err_1),
    .mx_req(mx_req), .mx_wr(mx_wr), .mx_addr(mx_addr), .mx_wdata(mx_wdata),
    .mx_gnt(mx_gnt_1), .mx_rvalid(mx_rvalid_1), .mx_rdata(mx_rdata_1), .mx_err(mx_err_1),
    .mem_addr(addr_1), .mem_enable(en_1), .mem_wr(wr_1), .mem_data_in(din_1),
    .mem_data_out(dout_1), .mem_err(mem_err));
  mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) u3 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_3),
    .if_rvalid(if_rvalid_3), .if_rdata(if_rdata_3), .if_err(if_err_3),
    .mx_req(mx_req), .mx_wr(mx_wr), .mx_addr(mx_addr), .mx_wdata(mx_wdata),
    .mx_gnt(mx_gnt_3), .mx_rvalid(mx_rvalid_3), .mx_rdata(mx_rdata_3), .mx_err(mx_err_3),
    .mem_addr(addr_3), .mem_enable(en_3), .mem_wr(wr_3), .mem_data_in(din_3),
    .mem_data_out(dout_3), .mem_err(mem_err));
  assign dout_1 = mem1[addr_1[7:0]];
  assign dout_3 = mem3[addr_3[7:0]];
  always @(posedge clk) begin
    if (rst) begin
      mem1[0] <= 16'h1111; mem1[2] <= 16'h2222; mem1[4] <= 16'h3333;
      mem3[0] <= 16'h1111; mem3[2] <= 16'h2222; mem3[4] <= 16'h3333;
    end else begin
      if (en_1 && wr_1) mem1[addr_1[7:0]] <= din_1;
      if (en_3 && wr_3) mem3[addr_3[7:0]] <= din_3;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic settle();
    #2;
  endtask
  task automatic do_reset();
    rst = 1; if_req = 0; mx_req = 0; mx_wr = 0; mem_err = 0;
    tick(); tick();
    rst = 0;
  endtask
  initial begin
    do_reset();
    settle();
    check("reset u1 outs", {if_gnt_1, mx_gnt_1, if_rvalid_1, mx_rvalid_1, en_1, wr_1, addr_1}, 0);
    check("reset u3 outs", {if_gnt_3, mx_gnt_3, if_rvalid_3, mx_rvalid_3, en_3, wr_3, addr_3}, 0);
    // 1: IF streaming reads at MEM_LAT=1
    if_req = 1; if_addr = 16'h0; settle();
    check("t1 gnt0", if_gnt_1, 1);
    tick(); if_addr = 16'h2; settle();
    check("t1 gnt1", {if_gnt_1, if_rvalid_1, if_rdata_1}, {2'b11, 16'h1111});
    tick(); if_addr = 16'h4; settle();
    check("t1 gnt2", {if_gnt_1, if_rvalid_1, if_rdata_1}, {2'b11, 16'h2222});
    tick(); if_req = 0; settle();
    check("t1 last", {if_gnt_1, if_rvalid_1, if_rdata_1}, {2'b01, 16'h3333});
    tick(); settle();
    check("t1 idle", {if_rvalid_1, if_rdata_1, en_1}, 0);
    // 2: MX store wins a tie, IF follows, MX load reads it back; 6: error on MX only
    do_reset();
    mx_req = 1; mx_wr = 1; mx_addr = 16'h40; mx_wdata = 16'hBEEF;
    if_req = 1; if_addr = 16'h2; settle();
    check("t2 tie", {if_gnt_1, mx_gnt_1}, 2'b01);
    tick(); mx_req = 0; settle();
    check("t2 store", {if_gnt_1, wr_1, addr_1, mx_rvalid_1, mx_rdata_1}, {2'b11, 16'h40, 1'b1, 16'h0});
    tick(); if_req = 0; mx_req = 1; mx_wr = 0; settle();
    check("t2 if ack", {mx_gnt_1, if_rvalid_1, if_rdata_1, wr_1}, {2'b11, 16'h2222, 1'b0});
    tick(); mx_req = 0; settle();
    check("t2 load", {mx_rvalid_1, mx_rdata_1}, {1'b1, 16'hBEEF});
    mx_req = 1; mx_addr = 16'h0;
    tick(); mx_req = 0; mem_err = 1; settle();
    check("t6 err", {mx_rvalid_1, mx_err_1, if_err_1, mx_rdata_1}, {3'b110, 16'h1111});
    tick(); mem_err = 0; settle();
    check("t6 quiet", {mx_rvalid_1, mx_err_1}, 0);
    // 3: starvation override, 4 MX then 1 IF, repeating
    do_reset();
    if_req = 1; if_addr = 16'h4; mx_req = 1; mx_wr = 0; mx_addr = 16'h0;
    for (int k = 0; k < 10; k++) begin
      settle();
      check($sformatf("t3 cyc%0d", k), {if_gnt_1, mx_gnt_1}, (k % 5 == 4) ? 2'b10 : 2'b01);
      tick();
    end
    // 4: MEM_LAT=3 timing, back-to-back in the completion cycle
    do_reset();
    if_req = 1; if_addr = 16'h2; settle();
    check("t4 gnt N", if_gnt_3, 1);
    tick(); if_addr = 16'h4; settle();
    check("t4 N+1", {if_gnt_3, en_3, if_rvalid_3}, 3'b010);
    tick(); settle();
    check("t4 N+2", {if_gnt_3, en_3, if_rvalid_3}, 3'b010);
    tick(); settle();
    check("t4 N+3", {if_gnt_3, en_3, if_rvalid_3, if_rdata_3}, {3'b111, 16'h2222});
    tick(); if_req = 0; tick(); tick(); settle();
    check("t4 N+6", {en_3, if_rvalid_3, if_rdata_3}, {2'b11, 16'h3333});
    tick(); settle();
    check("t4 N+7", {en_3, if_rvalid_3}, 0);
    // 5: reset in the cycle after a grant abandons the access
    do_reset();
    mx_req = 1; mx_wr = 0; mx_addr = 16'h2; settle();
    check("t5 gnt", mx_gnt_3, 1);
    tick(); mx_req = 0; rst = 1; settle();
    check("t5 in rst", {if_gnt_3, mx_gnt_3, mx_rvalid_3, en_3}, 0);
    tick(); rst = 0; settle();
    check("t5 after rst", {en_3, wr_3, addr_3, mx_rvalid_3, mx_rdata_3, mx_err_3}, 0);
    begin
      int seen = 0;
      for (int k = 0; k < 4; k++) begin
        tick(); settle();
        seen += int'(mx_rvalid_3);
      end
      check("t5 no rvalid", seen, 0);
    end
    if_req = 1; if_addr = 16'h0; settle();
    check("t5 regrant", {if_gnt_3, mx_gnt_3}, 2'b10);
    tick(); if_req = 0; tick(); tick(); settle();
    check("t5 read", {if_rvalid_3, if_rdata_3}, {1'b1, 16'h1111});
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
